// File: rtl/gpu_pkg.sv
// Shared GPU sprite-writer types and constants.
// Word layout, stride, AXI response codes and FSM states.
package gpu_pkg;

  localparam int SPRITE_WORDS        = 4;
  localparam int SPRITE_STRIDE_BYTES = 16;

  localparam logic [1:0] W_SX  = 2'd0;
  localparam logic [1:0] W_SY  = 2'd1;
  localparam logic [1:0] W_TEX = 2'd2;
  localparam logic [1:0] W_SSC = 2'd3;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    RESP
  } st_e;

endpackage

// File: rtl/axil_write_beat.sv
// Single AXI4-Lite write (AW + W + B) engine.
// Ports: start/addr/data in; done/resp out; AXI AW/W/B master signals.
module axil_write_beat
  import gpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  done,
  output logic [1:0]            resp,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  st_e st, st_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= IDLE;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      awaddr  <= '0;
      wdata   <= '0;
    end else begin
      st <= st_nxt;
      if (start) begin
        awvalid <= 1'b1;
        wvalid  <= 1'b1;
        awaddr  <= addr;
        wdata   <= data;
      end else begin
        // AW and W retire independently
        if (awready) awvalid <= 1'b0;
        if (wready)  wvalid  <= 1'b0;
      end
    end
  end

  always_comb begin
    st_nxt = st;
    unique case (st)
      IDLE: if (start) st_nxt = SEND;
      SEND: begin
        if ((!awvalid || awready) &&
            (!wvalid || wready))
          st_nxt = RESP;
      end
      // next beat may be chained on the B handshake
      RESP: if (bvalid) st_nxt = start ? SEND : IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  assign bready = (st == RESP);
  assign done   = bready & bvalid;
  assign resp   = bresp;

endmodule

// File: rtl/sprite_writer.sv
// AXI4-Lite write master: one sprite record -> 4 register writes.
// Ports: cmd valid/ready + fields in; done/err status; AXI AW/W/B out.
module sprite_writer
  import gpu_pkg::*;
#(
  parameter int ADDR_WIDTH   = 24,
  parameter int DATA_WIDTH   = 32,
  parameter int STRB_WIDTH   = DATA_WIDTH / 8,
  parameter int SHORT_WIDTH  = DATA_WIDTH / 4,
  parameter int SPRITE_COUNT = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  localparam int IDX_W = $clog2(SPRITE_COUNT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [IDX_W-1:0]       cmd_idx,
  input  logic [DATA_WIDTH-1:0]  cmd_sx,
  input  logic [DATA_WIDTH-1:0]  cmd_sy,
  input  logic [SHORT_WIDTH-1:0] cmd_stx,
  input  logic [SHORT_WIDTH-1:0] cmd_sty,
  input  logic [SHORT_WIDTH-1:0] cmd_stw,
  input  logic [SHORT_WIDTH-1:0] cmd_sth,
  input  logic [SHORT_WIDTH-1:0] cmd_ssc,
  output logic                   done,
  output logic                   err,
  output logic [ADDR_WIDTH-1:0]  awaddr,
  output logic [2:0]             awprot,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [DATA_WIDTH-1:0]  wdata,
  output logic [STRB_WIDTH-1:0]  wstrb,
  output logic                   wvalid,
  input  logic                   wready,
  input  logic [1:0]             bresp,
  input  logic                   bvalid,
  output logic                   bready
);

  st_e st, st_nxt;

  logic [1:0]             word;
  logic [IDX_W-1:0]       rec_idx;
  logic [DATA_WIDTH-1:0]  rec_sx, rec_sy;
  logic [SHORT_WIDTH-1:0] rec_stx, rec_sty;
  logic [SHORT_WIDTH-1:0] rec_stw, rec_sth;
  logic [SHORT_WIDTH-1:0] rec_ssc;

  logic accept, idx_ok, last;
  logic eng_start, eng_done;
  logic [1:0] eng_resp;

  logic [1:0]             nxt_word;
  logic [IDX_W-1:0]       s_idx;
  logic [DATA_WIDTH-1:0]  s_sx, s_sy;
  logic [SHORT_WIDTH-1:0] s_stx, s_sty;
  logic [SHORT_WIDTH-1:0] s_stw, s_sth;
  logic [SHORT_WIDTH-1:0] s_ssc;
  logic [ADDR_WIDTH-1:0]  nxt_addr;
  logic [DATA_WIDTH-1:0]  nxt_data;

  assign cmd_ready = (st == IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign idx_ok    = int'(cmd_idx) < SPRITE_COUNT;
  assign last      = (word == 2'(SPRITE_WORDS - 1));
  assign awprot    = 3'b000;
  assign wstrb     = '1;

  // Beat 0 launches in the accept cycle, straight from the cmd
  // inputs; later beats chain off each B handshake.
  assign eng_start = (accept & idx_ok) |
                     (eng_done & ~last & (st == SEND));

  always_comb begin
    nxt_word = accept ? 2'd0 : word + 2'd1;
    s_idx    = accept ? cmd_idx : rec_idx;
    s_sx     = accept ? cmd_sx  : rec_sx;
    s_sy     = accept ? cmd_sy  : rec_sy;
    s_stx    = accept ? cmd_stx : rec_stx;
    s_sty    = accept ? cmd_sty : rec_sty;
    s_stw    = accept ? cmd_stw : rec_stw;
    s_sth    = accept ? cmd_sth : rec_sth;
    s_ssc    = accept ? cmd_ssc : rec_ssc;
    nxt_addr = BASE_ADDR
             + ADDR_WIDTH'(s_idx) * ADDR_WIDTH'(SPRITE_STRIDE_BYTES)
             + ADDR_WIDTH'(nxt_word) * ADDR_WIDTH'(4);
    nxt_data = '0;
    unique case (nxt_word)
      W_SX:  nxt_data = s_sx;
      W_SY:  nxt_data = s_sy;
      W_TEX: nxt_data = {s_stx, s_sty, s_stw, s_sth};
      W_SSC: nxt_data = DATA_WIDTH'(s_ssc);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= IDLE;
      word    <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      rec_idx <= '0;
      rec_sx  <= '0;
      rec_sy  <= '0;
      rec_stx <= '0;
      rec_sty <= '0;
      rec_stw <= '0;
      rec_sth <= '0;
      rec_ssc <= '0;
    end else begin
      st   <= st_nxt;
      done <= (accept & ~idx_ok) |
              (eng_done & last & (st == SEND));
      if (accept) begin
        word    <= '0;
        err     <= ~idx_ok;
        rec_idx <= cmd_idx;
        rec_sx  <= cmd_sx;
        rec_sy  <= cmd_sy;
        rec_stx <= cmd_stx;
        rec_sty <= cmd_sty;
        rec_stw <= cmd_stw;
        rec_sth <= cmd_sth;
        rec_ssc <= cmd_ssc;
      end else if (eng_done) begin
        if (eng_resp != AXI_RESP_OKAY) err <= 1'b1;
        if (!last) word <= word + 2'd1;
      end
    end
  end

  always_comb begin
    st_nxt = st;
    unique case (st)
      IDLE: if (accept & idx_ok) st_nxt = SEND;
      SEND: if (eng_done & last) st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  axil_write_beat #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_beat (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (eng_start),
    .addr   (nxt_addr),
    .data   (nxt_data),
    .done   (eng_done),
    .resp   (eng_resp),
    .awaddr (awaddr),
    .awvalid(awvalid),
    .awready(awready),
    .wdata  (wdata),
    .wvalid (wvalid),
    .wready (wready),
    .bresp  (bresp),
    .bvalid (bvalid),
    .bready (bready)
  );

endmodule

// File: tb/tb_sprite_writer.sv
// Directed testbench for sprite_writer.
// AXI-Lite slave model with selectable backpressure.
module tb_sprite_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_idx;
  logic [31:0] cmd_sx, cmd_sy;
  logic [7:0]  cmd_stx, cmd_sty, cmd_stw, cmd_sth, cmd_ssc;
  logic        done, err;
  logic [23:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  always #5 clk = ~clk;

  sprite_writer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_idx(cmd_idx), .cmd_sx(cmd_sx), .cmd_sy(cmd_sy),
    .cmd_stx(cmd_stx), .cmd_sty(cmd_sty),
    .cmd_stw(cmd_stw), .cmd_sth(cmd_sth), .cmd_ssc(cmd_ssc),
    .done(done), .err(err),
    .awaddr(awaddr), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb),
    .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int tests = 0;
  int fails = 0;

  // slave model state
  int          mode = 0;   // 0 always ready, 1 W before AW, 2 random
  int          err_at = -1;
  bit          have_aw, have_w, b_fire, aw_hold, w_hold;
  logic [23:0] cap_addr, hold_addr;
  logic [31:0] cap_data, hold_data;
  int          aw_wait, outst, proto, done_cnt, aw_cycles;
  logic [23:0] log_addr[$];
  logic [31:0] log_data[$];

  // Ready/valid decided at negedge; handshakes they imply
  // happen at the following posedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      awready = 0; wready = 0; bvalid = 0; bresp = 0;
      have_aw = 0; have_w = 0; b_fire = 0;
      aw_hold = 0; w_hold = 0; aw_wait = 0; outst = 0;
    end else begin
      if (b_fire) begin
        bvalid = 0; bresp = 0; b_fire = 0;
      end
      case (mode)
        1: begin
          wready  = 1;
          awready = (aw_wait >= 3);
        end
        2: begin
          awready = 1'($urandom_range(0, 1));
          wready  = 1'($urandom_range(0, 1));
        end
        default: begin
          awready = 1; wready = 1;
        end
      endcase
      if (have_aw && have_w && !bvalid &&
          (mode != 2 || $urandom_range(0, 1) == 1)) begin
        bvalid = 1;
        bresp  = (log_addr.size() == err_at) ? 2'b10 : 2'b00;
      end
      if (aw_hold && (!awvalid || awaddr !== hold_addr)) proto++;
      if (w_hold && (!wvalid || wdata !== hold_data)) proto++;
      if (awvalid && have_aw) proto++;
      if (wvalid && have_w) proto++;
      if (bready && !(have_aw && have_w)) proto++;
      if (awprot !== 3'b000 || wstrb !== 4'hF) proto++;
      if (awvalid) aw_cycles++;
      if (done) done_cnt++;
      if (bvalid && bready) begin
        log_addr.push_back(cap_addr);
        log_data.push_back(cap_data);
        have_aw = 0; have_w = 0; b_fire = 1;
        outst--;
      end
      if (awvalid && awready) begin
        have_aw = 1; cap_addr = awaddr; aw_wait = 0;
        outst++;
        if (outst > 1) proto++;
      end else if (awvalid && mode == 1) begin
        aw_wait++;
      end
      if (wvalid && wready) begin
        have_w = 1; cap_data = wdata;
      end
      aw_hold   = awvalid && !awready;
      hold_addr = awaddr;
      w_hold    = wvalid && !wready;
      hold_data = wdata;
    end
  end

  task automatic drive_cmd(
    input logic [3:0]  idx,
    input logic [31:0] sx, sy,
    input logic [7:0]  tx, ty, tw, th, sc,
    input bit          hold
  );
    int n = 0;
    cmd_idx = idx; cmd_sx = sx; cmd_sy = sy;
    cmd_stx = tx; cmd_sty = ty; cmd_stw = tw; cmd_sth = th;
    cmd_ssc = sc; cmd_valid = 1;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL accept_timeout idx=%0d cmd_ready=%b want 1",
               idx, cmd_ready);
    end
    @(negedge clk);
    if (!hold) cmd_valid = 0;
  endtask

  task automatic wait_done(input int target, input string nm);
    int n = 0;
    while (done_cnt < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (done_cnt < target) begin
      fails++;
      $display("FAIL %s_done_timeout got %0d want %0d",
               nm, done_cnt, target);
    end
    repeat (5) @(negedge clk);
    tests++;
    if (done_cnt != target) begin
      fails++;
      $display("FAIL %s_done_count got %0d want %0d",
               nm, done_cnt, target);
    end
  endtask

  task automatic test_reset;
    rst_n = 0; cmd_valid = 0; cmd_idx = 0;
    cmd_sx = 0; cmd_sy = 0; cmd_stx = 0; cmd_sty = 0;
    cmd_stw = 0; cmd_sth = 0; cmd_ssc = 0;
    mode = 0; err_at = -1;
    repeat (2) @(negedge clk);
    tests++;
    if ({cmd_ready, awvalid, wvalid, bready, done, err}
        !== 6'b100000) begin
      fails++;
      $display("FAIL reset_ctl got %b want 100000",
               {cmd_ready, awvalid, wvalid, bready, done, err});
    end
    tests++;
    if ({awaddr, wdata} !== 56'd0) begin
      fails++;
      $display("FAIL reset_data got %h/%h want 0/0", awaddr, wdata);
    end
    #2 rst_n = 1;
    @(negedge clk);
    // abort a write stalled on AW
    mode = 1;
    drive_cmd(4'd3, 32'd7, 32'd8, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 0);
    tests++;
    if (awvalid !== 1'b1) begin
      fails++;
      $display("FAIL midsend_pre awvalid=%b want 1", awvalid);
    end
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    tests++;
    if ({awvalid, wvalid, bready, cmd_ready, err, done}
        !== 6'b000100) begin
      fails++;
      $display("FAIL midsend_reset got %b want 000100",
               {awvalid, wvalid, bready, cmd_ready, err, done});
    end
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    mode = 0;
    tests++;
    if (log_addr.size() != 0) begin
      fails++;
      $display("FAIL midsend_writes got %0d want 0", log_addr.size());
    end
  endtask

  task automatic check_four(
    input int base, input string nm,
    input logic [23:0] a0,
    input logic [31:0] d0, d1, d2, d3
  );
    logic [31:0] ed[4];
    logic [23:0] ga;
    logic [31:0] gd;
    ed = '{d0, d1, d2, d3};
    for (int i = 0; i < 4; i++) begin
      ga = (base + i < log_addr.size()) ? log_addr[base+i] : 'x;
      gd = (base + i < log_data.size()) ? log_data[base+i] : 'x;
      tests++;
      if (ga !== a0 + 24'(4 * i) || gd !== ed[i]) begin
        fails++;
        $display("FAIL %s_w%0d got %h=%h want %h=%h", nm, i,
                 ga, gd, a0 + 24'(4 * i), ed[i]);
      end
    end
  endtask

  task automatic test_basic;
    int base = log_addr.size();
    int d0 = done_cnt;
    drive_cmd(4'd2, 32'd300, 32'd100,
              8'd0, 8'd0, 8'd64, 8'd64, 8'd2, 0);
    tests++;
    if ({awvalid, wvalid, cmd_ready} !== 3'b110) begin
      fails++;
      $display("FAIL basic_latency got %b want 110",
               {awvalid, wvalid, cmd_ready});
    end
    wait_done(d0 + 1, "basic");
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL basic_err got %b want 0", err);
    end
    check_four(base, "basic", 24'h20,
               32'd300, 32'd100, 32'h00004040, 32'h2);
  endtask

  task automatic test_w_before_aw;
    int base = log_addr.size();
    int d0 = done_cnt;
    int p0 = proto;
    mode = 1;
    drive_cmd(4'd2, 32'd300, 32'd100,
              8'd0, 8'd0, 8'd64, 8'd64, 8'd2, 0);
    wait_done(d0 + 1, "wfirst");
    mode = 0;
    check_four(base, "wfirst", 24'h20,
               32'd300, 32'd100, 32'h00004040, 32'h2);
    tests++;
    if (proto != p0) begin
      fails++;
      $display("FAIL wfirst_protocol got %0d violations want 0",
               proto - p0);
    end
  endtask

  task automatic test_slverr;
    int base = log_addr.size();
    int d0 = done_cnt;
    err_at = base + 1;
    drive_cmd(4'd5, 32'h11, 32'h22,
              8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h3C, 0);
    wait_done(d0 + 1, "slverr");
    err_at = -1;
    tests++;
    if (err !== 1'b1) begin
      fails++;
      $display("FAIL slverr_err got %b want 1", err);
    end
    check_four(base, "slverr", 24'h50,
               32'h11, 32'h22, 32'hA1B2C3D4, 32'h3C);
    drive_cmd(4'd1, 32'h5, 32'h6,
              8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 0);
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL slverr_clear got %b want 0", err);
    end
    wait_done(d0 + 2, "slverr_next");
  endtask

  task automatic test_bad_idx;
    int base = log_addr.size();
    int d0 = done_cnt;
    int a0 = aw_cycles;
    drive_cmd(4'd10, 32'h1, 32'h2,
              8'h3, 8'h4, 8'h5, 8'h6, 8'h7, 0);
    tests++;
    if ({done, err, cmd_ready, awvalid} !== 4'b1110) begin
      fails++;
      $display("FAIL badidx_status got %b want 1110",
               {done, err, cmd_ready, awvalid});
    end
    repeat (6) @(negedge clk);
    tests++;
    if (aw_cycles != a0 || log_addr.size() != base) begin
      fails++;
      $display("FAIL badidx_nowrite got %0d/%0d want 0/0",
               aw_cycles - a0, log_addr.size() - base);
    end
    tests++;
    if (done_cnt != d0 + 1) begin
      fails++;
      $display("FAIL badidx_done got %0d want %0d", done_cnt, d0 + 1);
    end
  endtask

  task automatic test_back_to_back;
    int base = log_addr.size();
    int d0 = done_cnt;
    int p0 = proto;
    mode = 2;
    drive_cmd(4'd0, 32'd1, 32'd2,
              8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 1);
    drive_cmd(4'd9, 32'hDEADBEEF, 32'd7,
              8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hFF, 0);
    wait_done(d0 + 2, "b2b");
    mode = 0;
    check_four(base, "b2b_a", 24'h00,
               32'd1, 32'd2, 32'h01020304, 32'h5);
    check_four(base + 4, "b2b_b", 24'h90,
               32'hDEADBEEF, 32'd7, 32'hAABBCCDD, 32'hFF);
    tests++;
    if (proto != p0 || log_addr.size() != base + 8) begin
      fails++;
      $display("FAIL b2b_protocol got %0d viol %0d writes want 0 8",
               proto - p0, log_addr.size() - base);
    end
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL b2b_err got %b want 0", err);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_w_before_aw;
    test_slverr;
    test_bad_idx;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

endmodule
